// File: rtl/multi_phase_signal_controller.sv
// N-approach round-robin traffic signal controller with a built-in interval
// timer and latched vehicle-demand registers. Lamp outputs are registered.
module multi_phase_signal_controller #(
  parameter int unsigned N_PHASES  = 4,
  parameter int unsigned TIMER_W   = 8,
  parameter int unsigned MIN_GREEN = 10,
  parameter int unsigned MAX_GREEN = 40,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  localparam int unsigned PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [N_PHASES-1:0] car,
  output logic [N_PHASES-1:0] green,
  output logic [N_PHASES-1:0] yellow,
  output logic [N_PHASES-1:0] red,
  output logic [PW-1:0]       phase,
  output logic [N_PHASES-1:0] req
);

  localparam logic [TIMER_W-1:0] MinGreen   = TIMER_W'(MIN_GREEN);
  localparam logic [TIMER_W-1:0] MaxGreen   = TIMER_W'(MAX_GREEN);
  localparam logic [TIMER_W-1:0] YellowLast = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] AllRedLast = TIMER_W'(ALLRED_T - 1);
  localparam logic [TIMER_W-1:0] CntMax     = '1;
  localparam logic [N_PHASES-1:0] OneBit    = N_PHASES'(1);

  typedef enum logic [1:0] {
    StGreen  = 2'd0,
    StYellow = 2'd1,
    StAllRed = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [TIMER_W-1:0]  cnt_q, cnt_d;
  logic [N_PHASES-1:0] req_q, req_d;
  logic [N_PHASES-1:0] green_q, yellow_q, red_q;
  logic [N_PHASES-1:0] green_d, yellow_d, red_d;

  logic [N_PHASES-1:0] phase_onehot;
  logic [N_PHASES-1:0] serving;
  logic                other_req;
  logic                car_here;
  logic                gap_out;
  logic                max_out;
  logic                enter_green;
  logic [PW-1:0]       next_phase;
  logic [PW-1:0]       cand;
  logic                found;
  int unsigned         idx;

  always_comb begin
    phase_onehot = OneBit << phase_q;
    other_req    = |(req_q & ~phase_onehot);
    car_here     = |(car & phase_onehot);
    gap_out      = (cnt_q >= MinGreen) && !car_here;
    max_out      = (cnt_q >= MaxGreen);
  end

  // Round-robin scan starting after the current phase; the old phase is tried last.
  always_comb begin
    next_phase = phase_q;
    found      = 1'b0;
    idx        = 0;
    cand       = '0;
    for (int unsigned k = 1; k <= N_PHASES; k++) begin
      idx  = (32'(phase_q) + k) % N_PHASES;
      cand = PW'(idx);
      if (!found && req_q[cand]) begin
        found      = 1'b1;
        next_phase = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      StGreen: begin
        if (other_req && (gap_out || max_out)) begin
          state_d = StYellow;
        end
      end
      StYellow: begin
        if (tick && (cnt_q == YellowLast)) begin
          state_d = StAllRed;
        end
      end
      StAllRed: begin
        if (tick && (cnt_q == AllRedLast)) begin
          state_d = StGreen;
          phase_d = next_phase;
        end
      end
      default: begin
        state_d = StGreen;
        phase_d = '0;
      end
    endcase
  end

  // Any state change restarts the interval, so an exit on a tick cycle starts at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A new request and service of the same approach on one edge resolve as served.
  always_comb begin
    enter_green = (state_d == StGreen) && (state_q != StGreen);
    serving     = (state_q == StGreen) ? phase_onehot : '0;
    req_d       = req_q | (car & ~serving);
    if (enter_green) begin
      req_d = req_d & ~(OneBit << phase_d);
    end
  end

  always_comb begin
    green_d  = (state_d == StGreen)  ? (OneBit << phase_d) : '0;
    yellow_d = (state_d == StYellow) ? (OneBit << phase_d) : '0;
    red_d    = ~(green_d | yellow_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StGreen;
      phase_q  <= '0;
      cnt_q    <= '0;
      req_q    <= '0;
      green_q  <= OneBit;
      yellow_q <= '0;
      red_q    <= ~OneBit;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
    end
  end

  assign green  = green_q;
  assign yellow = yellow_q;
  assign red    = red_q;
  assign phase  = phase_q;
  assign req    = req_q;

endmodule

// File: tb/tb_multi_phase_signal_controller.sv
// Directed bench for multi_phase_signal_controller: 4 approaches, MIN=3, MAX=6,
// YELLOW=2, ALLRED=1, with hand-derived lamp/phase/request sequences.
module tb_multi_phase_signal_controller;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b1;
  logic [3:0] car   = '0;
  logic [3:0] green, yellow, red, req;
  logic [1:0] phase;
  logic [11:0] lamps;

  int n_pass  = 0;
  int n_total = 0;

  // {green, yellow, red}
  localparam logic [11:0] LG0 = 12'b0001_0000_1110;
  localparam logic [11:0] LG1 = 12'b0010_0000_1101;
  localparam logic [11:0] LG2 = 12'b0100_0000_1011;
  localparam logic [11:0] LG3 = 12'b1000_0000_0111;
  localparam logic [11:0] LY0 = 12'b0000_0001_1110;
  localparam logic [11:0] LY2 = 12'b0000_0100_1011;
  localparam logic [11:0] LAR = 12'b0000_0000_1111;

  assign lamps = {green, yellow, red};

  multi_phase_signal_controller #(
    .N_PHASES (4),
    .TIMER_W  (8),
    .MIN_GREEN(3),
    .MAX_GREEN(6),
    .YELLOW_T (2),
    .ALLRED_T (1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .car   (car),
    .green (green),
    .yellow(yellow),
    .red   (red),
    .phase (phase),
    .req   (req)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1 time unit after an edge; the next edge is the first live one.
  task automatic do_reset();
    rst_n = 1'b0;
    car   = '0;
    tick  = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (lamps !== LG0) $display("FAIL reset_lamps got %b want %b", lamps, LG0); else n_pass++;
    for (int i = 0; i < 30; i++) begin
      step(1);
      n_total++;
      if ({lamps, phase, req} !== {LG0, 2'd0, 4'b0000})
        $display("FAIL reset_idle cyc%0d got %b/%0d/%b want %b/0/0000", i, lamps, phase, req, LG0);
      else n_pass++;
    end
  endtask

  task automatic test_gap_out();
    do_reset();
    car = 4'b0100;
    step(1);
    n_total++; if (req !== 4'b0100) $display("FAIL gap_req got %b want 0100", req); else n_pass++;
    car = '0;
    step(2);
    n_total++; if (lamps !== LG0) $display("FAIL gap_hold got %b want %b", lamps, LG0); else n_pass++;
    step(1);
    n_total++; if (lamps !== LY0) $display("FAIL gap_yel1 got %b want %b", lamps, LY0); else n_pass++;
    step(1);
    n_total++; if (lamps !== LY0) $display("FAIL gap_yel2 got %b want %b", lamps, LY0); else n_pass++;
    step(1);
    n_total++; if (lamps !== LAR) $display("FAIL gap_allred got %b want %b", lamps, LAR); else n_pass++;
    step(1);
    n_total++; if (lamps !== LG2) $display("FAIL gap_green2 got %b want %b", lamps, LG2); else n_pass++;
    n_total++; if (phase !== 2'd2) $display("FAIL gap_phase got %0d want 2", phase); else n_pass++;
    n_total++; if (req !== 4'b0000) $display("FAIL gap_req_clr got %b want 0000", req); else n_pass++;
  endtask

  task automatic test_max_out();
    do_reset();
    car = 4'b0011;
    step(1);
    n_total++; if (req !== 4'b0010) $display("FAIL max_req got %b want 0010", req); else n_pass++;
    car = 4'b0001;
    step(5);
    n_total++; if (lamps !== LG0) $display("FAIL max_hold got %b want %b", lamps, LG0); else n_pass++;
    step(1);
    n_total++; if (lamps !== LY0) $display("FAIL max_yel got %b want %b", lamps, LY0); else n_pass++;
    step(2);
    n_total++; if (lamps !== LAR) $display("FAIL max_allred got %b want %b", lamps, LAR); else n_pass++;
    step(1);
    n_total++; if (lamps !== LG1) $display("FAIL max_green1 got %b want %b", lamps, LG1); else n_pass++;
    n_total++; if (phase !== 2'd1) $display("FAIL max_phase got %0d want 1", phase); else n_pass++;
    n_total++; if (req !== 4'b0001) $display("FAIL max_req0 got %b want 0001", req); else n_pass++;
    car = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    car = 4'b0100;
    step(1);
    car = '0;
    step(6);
    n_total++; if (lamps !== LG2) $display("FAIL wrap_start got %b want %b", lamps, LG2); else n_pass++;
    car = 4'b1001;
    step(1);
    n_total++; if (req !== 4'b1001) $display("FAIL wrap_req got %b want 1001", req); else n_pass++;
    car = '0;
    step(5);
    n_total++; if (lamps !== LAR) $display("FAIL wrap_allred got %b want %b", lamps, LAR); else n_pass++;
    step(1);
    n_total++; if ({lamps, phase, req} !== {LG3, 2'd3, 4'b0001})
      $display("FAIL wrap_to3 got %b/%0d/%b want %b/3/0001", lamps, phase, req, LG3); else n_pass++;
    step(6);
    n_total++; if (lamps !== LAR) $display("FAIL wrap_allred2 got %b want %b", lamps, LAR); else n_pass++;
    step(1);
    n_total++; if ({lamps, phase, req} !== {LG0, 2'd0, 4'b0000})
      $display("FAIL wrap_to0 got %b/%0d/%b want %b/0/0000", lamps, phase, req, LG0); else n_pass++;
  endtask

  task automatic test_yellow_request();
    do_reset();
    car = 4'b0100;
    step(1);
    car = '0;
    step(6);
    car = 4'b0010;
    step(1);
    n_total++; if (req !== 4'b0010) $display("FAIL yreq_req1 got %b want 0010", req); else n_pass++;
    car = '0;
    step(3);
    n_total++; if (lamps !== LY2) $display("FAIL yreq_yel got %b want %b", lamps, LY2); else n_pass++;
    car = 4'b0100;
    step(1);
    n_total++; if (req !== 4'b0110) $display("FAIL yreq_latched got %b want 0110", req); else n_pass++;
    car = '0;
    step(2);
    n_total++; if ({lamps, phase, req} !== {LG1, 2'd1, 4'b0100})
      $display("FAIL yreq_to1 got %b/%0d/%b want %b/1/0100", lamps, phase, req, LG1); else n_pass++;
    step(7);
    n_total++; if ({lamps, phase, req} !== {LG2, 2'd2, 4'b0000})
      $display("FAIL yreq_to2 got %b/%0d/%b want %b/2/0000", lamps, phase, req, LG2); else n_pass++;
  endtask

  task automatic test_tick_gating();
    do_reset();
    car = 4'b0100;
    step(1);
    car  = '0;
    tick = 1'b0;
    step(10);
    n_total++; if (lamps !== LG0) $display("FAIL tick_green_hold got %b want %b", lamps, LG0); else n_pass++;
    tick = 1'b1;
    step(2);
    n_total++; if (lamps !== LG0) $display("FAIL tick_green_min got %b want %b", lamps, LG0); else n_pass++;
    step(1);
    n_total++; if (lamps !== LY0) $display("FAIL tick_yel got %b want %b", lamps, LY0); else n_pass++;
    tick = 1'b0;
    step(3);
    n_total++; if (lamps !== LY0) $display("FAIL tick_yel_hold got %b want %b", lamps, LY0); else n_pass++;
    tick = 1'b1;
    step(1);
    n_total++; if (lamps !== LY0) $display("FAIL tick_yel_last got %b want %b", lamps, LY0); else n_pass++;
    step(1);
    n_total++; if (lamps !== LAR) $display("FAIL tick_allred got %b want %b", lamps, LAR); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    car = 4'b1010;
    step(1);
    car = '0;
    step(3);
    n_total++; if ({lamps, req} !== {LY0, 4'b1010})
      $display("FAIL areset_pre got %b/%b want %b/1010", lamps, req, LY0); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if ({lamps, phase, req} !== {LG0, 2'd0, 4'b0000})
      $display("FAIL areset_now got %b/%0d/%b want %b/0/0000", lamps, phase, req, LG0); else n_pass++;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_gap_out();
    test_max_out();
    test_wrap();
    test_yellow_request();
    test_tick_gating();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
